matrix_seq_ctrl: RTL and testbench
==================================

Name: matrix_seq_ctrl

Overview:
- Time-multiplexed 2x2 matrix engine: one shared WIDTH x WIDTH unsigned multiplier and one accumulator are sequenced over 4 or 8 cycles.
- Computes either the element-wise product (OP=0) or the matrix product (OP=1).
- Area-reduced, sequential counterpart of the fully parallel 2x2 matrix datapath (12 multipliers).
- Sits between a host issuing START/OP/operands and downstream logic consuming C on DONE.

Parameters:
WIDTH, 8, operand element width; products and results are 2*WIDTH bits

Ports:
clk    input   1        rising-edge clock
rst_n  input   1        asynchronous active-low reset
START  input   1        request; sampled in IDLE or FIN state
OP     input   1        0 = element-wise, 1 = matrix multiply; latched on accept
A11, A12, A21, A22  input  WIDTH  matrix A elements; latched on accept
B11, B12, B21, B22  input  WIDTH  matrix B elements; latched on accept
BUSY   output  1        high while in MUL state
DONE   output  1        one-cycle pulse; C valid
OVF    output  1        OP=1 sum exceeded 2*WIDTH bits in any element of the last op
C11, C12, C21, C22  output  2*WIDTH  result registers, held until next completion

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE, step counter=0, accumulator=0.
  - BUSY=0, DONE=0, OVF=0, all C=0.
  - Operand/OP latches cleared.
  - Reset mid-operation aborts immediately; C keeps no partial result (all 0).
- States: IDLE, MUL, FIN.
  - IDLE: START=1 at an edge -> latch OP, A, B; cnt=0; acc=0; go MUL.
  - MUL: BUSY=1. Each edge performs one step: product P = a_sel*b_sel (2*WIDTH bits).
    - Even OP=1 step: acc = P.
    - Odd OP=1 step: acc_sum = acc + P, with the carry-out recorded.
    - cnt increments each step.
    - Last step is cnt=3 for OP=0 or cnt=7 for OP=1; after it -> FIN.
  - FIN: DONE=1 for exactly one cycle.
    - START=1 -> accept a new op directly (go MUL, relatch).
    - Otherwise -> IDLE.
- Step order, OP=0 (each step writes its C register directly):
  - s0 A11*B11 -> C11
  - s1 A12*B12 -> C12
  - s2 A21*B21 -> C21
  - s3 A22*B22 -> C22
- Step order, OP=1 (C register written at the odd step with acc+P):
  - s0 A11*B11, s1 +A12*B21 -> C11
  - s2 A11*B12, s3 +A12*B22 -> C12
  - s4 A21*B11, s5 +A22*B21 -> C21
  - s6 A21*B12, s7 +A22*B22 -> C22
- C register write rules:
  - C11..C22 update only at the writing steps of the active op.
  - Untouched registers are not modified mid-op.
  - All four reflect the new op when DONE=1.
- Arithmetic:
  - Unsigned throughout.
  - OP=1 sums are truncated modulo 2^(2*WIDTH).
  - OVF is cleared on accept and set (sticky until next accept) if any odd-step carry-out=1.
  - OP=0 never sets OVF.
- Latency:
  - Accept edge = edge 0; DONE is high in the cycle after edge N.
  - N=4 for OP=0, N=8 for OP=1.
  - Throughput with back-to-back START in FIN: one op per N+1 cycles.
- START while BUSY=1 is ignored.
- OP and operand input changes during MUL are ignored (latched copies are used).
- START held high continuously: a new op is accepted in each FIN cycle.

Test Plan:
- OP=0, A=(1,2,3,4), B=(5,6,7,8), START 1 cycle -> BUSY for 4 cycles; DONE in 5th cycle; C=(5,12,21,32); OVF=0.
- OP=1, same operands -> DONE in 9th cycle after accept; C11=19, C12=22, C21=43, C22=50; OVF=0.
- OP=1, all elements 255 -> each C=64514 (130050 mod 65536); OVF=1; a following OP=0 op clears OVF.
- START pulses and operand changes on cycles 2 and 5 of an OP=1 op -> ignored; result matches the originally latched operands; single DONE pulse.
- START held high, alternating OP per accept -> ops accepted in FIN cycles at a period of 5/9 cycles; DONE pulses align; results correct per op.
- rst_n low at step 5 of OP=1 -> all outputs 0 asynchronously; after release the FSM is in IDLE; a new START completes normally.

Source files
------------

// File: rtl/matrix_seq_ctrl_if.sv
// Host-side bundle for matrix_seq_ctrl: request, operands and results.
interface matrix_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic               START;
    logic               OP;
    logic [WIDTH-1:0]   A11, A12, A21, A22;
    logic [WIDTH-1:0]   B11, B12, B21, B22;
    logic               BUSY;
    logic               DONE;
    logic               OVF;
    logic [2*WIDTH-1:0] C11, C12, C21, C22;

    // Host drives the request and operands, observes status and results.
    modport master (
        output START, OP,
        output A11, A12, A21, A22,
        output B11, B12, B21, B22,
        input  BUSY, DONE, OVF,
        input  C11, C12, C21, C22
    );

    // Engine receives the request and operands, drives status and results.
    modport slave (
        input  START, OP,
        input  A11, A12, A21, A22,
        input  B11, B12, B21, B22,
        output BUSY, DONE, OVF,
        output C11, C12, C21, C22
    );
endinterface

// File: rtl/matrix_seq_ctrl.sv
// Time-multiplexed 2x2 matrix engine: one shared multiplier and one accumulator
// sequenced over 4 (element-wise) or 8 (matrix product) cycles.
module matrix_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    matrix_seq_ctrl_if.slave bus
);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

    state_t           r_state;
    state_t           w_next;

    logic             r_op;
    logic [WIDTH-1:0] r_a11, r_a12, r_a21, r_a22;
    logic [WIDTH-1:0] r_b11, r_b12, r_b21, r_b22;
    logic [2:0]       r_cnt;
    logic [PW-1:0]    r_acc;
    logic             r_ovf;
    logic [PW-1:0]    r_c11, r_c12, r_c21, r_c22;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_a, w_b;
    logic [PW-1:0]    w_prod;
    logic [PW:0]      w_sum;
    logic [PW-1:0]    w_result;
    logic             w_write;
    logic [1:0]       w_idx;

    assign w_accept = bus.START && ((r_state == IDLE) || (r_state == FIN));
    assign w_last   = r_op ? (r_cnt == 3'd7) : (r_cnt == 3'd3);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic: FIN can chain straight into a new op.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? MUL : IDLE;
            MUL:     w_next = w_last ? FIN : MUL;
            FIN:     w_next = w_accept ? MUL : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Status outputs decoded from state.
    always_comb begin
        bus.BUSY = (r_state == MUL);
        bus.DONE = (r_state == FIN);
    end

    // Operand selection for the current step.
    always_comb begin
        w_a = '0;
        w_b = '0;
        if (!r_op) begin
            case (r_cnt[1:0])
                2'd0:    begin w_a = r_a11; w_b = r_b11; end
                2'd1:    begin w_a = r_a12; w_b = r_b12; end
                2'd2:    begin w_a = r_a21; w_b = r_b21; end
                default: begin w_a = r_a22; w_b = r_b22; end
            endcase
        end else begin
            case (r_cnt)
                3'd0:    begin w_a = r_a11; w_b = r_b11; end
                3'd1:    begin w_a = r_a12; w_b = r_b21; end
                3'd2:    begin w_a = r_a11; w_b = r_b12; end
                3'd3:    begin w_a = r_a12; w_b = r_b22; end
                3'd4:    begin w_a = r_a21; w_b = r_b11; end
                3'd5:    begin w_a = r_a22; w_b = r_b21; end
                3'd6:    begin w_a = r_a21; w_b = r_b12; end
                default: begin w_a = r_a22; w_b = r_b22; end
            endcase
        end
    end

    assign w_prod   = {{WIDTH{1'b0}}, w_a} * {{WIDTH{1'b0}}, w_b};
    assign w_sum    = {1'b0, r_acc} + {1'b0, w_prod};
    assign w_result = r_op ? w_sum[PW-1:0] : w_prod;
    // Element-wise writes every step; matrix product writes on the odd (sum) steps.
    assign w_write  = (r_state == MUL) && (!r_op || r_cnt[0]);
    assign w_idx    = r_op ? r_cnt[2:1] : r_cnt[1:0];

    // Operand latch, step counter, accumulator and overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op  <= 1'b0;
            r_a11 <= '0; r_a12 <= '0; r_a21 <= '0; r_a22 <= '0;
            r_b11 <= '0; r_b12 <= '0; r_b21 <= '0; r_b22 <= '0;
            r_cnt <= '0;
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_op  <= bus.OP;
            r_a11 <= bus.A11; r_a12 <= bus.A12; r_a21 <= bus.A21; r_a22 <= bus.A22;
            r_b11 <= bus.B11; r_b12 <= bus.B12; r_b21 <= bus.B21; r_b22 <= bus.B22;
            r_cnt <= '0;
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (r_state == MUL) begin
            r_cnt <= r_cnt + 3'd1;
            if (r_op) begin
                if (!r_cnt[0]) begin
                    r_acc <= w_prod;
                end else begin
                    r_acc <= w_sum[PW-1:0];
                    r_ovf <= r_ovf | w_sum[PW];
                end
            end
        end
    end

    // Result registers: only the register addressed by a writing step changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c11 <= '0; r_c12 <= '0; r_c21 <= '0; r_c22 <= '0;
        end else if (w_write) begin
            case (w_idx)
                2'd0:    r_c11 <= w_result;
                2'd1:    r_c12 <= w_result;
                2'd2:    r_c21 <= w_result;
                default: r_c22 <= w_result;
            endcase
        end
    end

    assign bus.OVF = r_ovf;
    assign bus.C11 = r_c11;
    assign bus.C12 = r_c12;
    assign bus.C21 = r_c21;
    assign bus.C22 = r_c22;
endmodule

// File: tb/tb_matrix_seq_ctrl.sv
// Directed testbench for matrix_seq_ctrl with hand-computed expected results.
module tb_matrix_seq_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    matrix_seq_ctrl_if #(.WIDTH(W)) bus ();

    matrix_seq_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [63:0] cvec();
        return {bus.C11, bus.C12, bus.C21, bus.C22};
    endfunction

    task automatic set_ops(input logic op,
                           input logic [7:0] a11, a12, a21, a22,
                           input logic [7:0] b11, b12, b21, b22);
        bus.OP  = op;
        bus.A11 = a11; bus.A12 = a12; bus.A21 = a21; bus.A22 = a22;
        bus.B11 = b11; bus.B12 = b12; bus.B21 = b21; bus.B22 = b22;
    endtask

    // Single-cycle START pulse; returns just after the accept edge.
    task automatic start_op(input logic op,
                            input logic [7:0] a11, a12, a21, a22,
                            input logic [7:0] b11, b12, b21, b22);
        @(negedge clk);
        set_ops(op, a11, a12, a21, a22, b11, b12, b21, b22);
        bus.START = 1'b1;
        @(posedge clk);
        #1 bus.START = 1'b0;
    endtask

    // Counts sampled cycles after the accept edge until DONE (0 if never seen).
    task automatic wait_done(output int cyc, output int busy_cyc);
        cyc = 0;
        busy_cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.BUSY) busy_cyc++;
            if (bus.DONE) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [63:0] got;
        #12;
        got = cvec();
        checks++;
        if ({bus.BUSY, bus.DONE, bus.OVF} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got BUSY/DONE/OVF=%b expected 000", {bus.BUSY, bus.DONE, bus.OVF});
        end
        checks++;
        if (got !== 64'h0) begin
            errors++;
            $display("FAIL reset_c: got %h expected 0", got);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got BUSY=%b expected 0", bus.BUSY);
        end
    endtask

    task automatic test_elementwise();
        int cyc, busy_cyc;
        logic [63:0] got;
        start_op(1'b0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
        wait_done(cyc, busy_cyc);
        got = cvec();
        checks++;
        if (cyc !== 5) begin
            errors++;
            $display("FAIL ew_latency: got DONE cycle %0d expected 5", cyc);
        end
        checks++;
        if (busy_cyc !== 4) begin
            errors++;
            $display("FAIL ew_busy: got %0d BUSY cycles expected 4", busy_cyc);
        end
        checks++;
        if (got !== {16'd5, 16'd12, 16'd21, 16'd32}) begin
            errors++;
            $display("FAIL ew_result: got %h expected %h", got, {16'd5, 16'd12, 16'd21, 16'd32});
        end
        checks++;
        if (bus.OVF !== 1'b0) begin
            errors++;
            $display("FAIL ew_ovf: got %b expected 0", bus.OVF);
        end
        @(negedge clk);
        got = cvec();
        checks++;
        if (bus.DONE !== 1'b0 || got !== {16'd5, 16'd12, 16'd21, 16'd32}) begin
            errors++;
            $display("FAIL ew_hold: got DONE=%b C=%h expected DONE=0 C unchanged", bus.DONE, got);
        end
    endtask

    task automatic test_matmul();
        int cyc, busy_cyc;
        logic [63:0] got;
        start_op(1'b1, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
        wait_done(cyc, busy_cyc);
        got = cvec();
        checks++;
        if (cyc !== 9 || busy_cyc !== 8) begin
            errors++;
            $display("FAIL mm_latency: got DONE cycle %0d BUSY %0d expected 9 and 8", cyc, busy_cyc);
        end
        checks++;
        if (got !== {16'd19, 16'd22, 16'd43, 16'd50}) begin
            errors++;
            $display("FAIL mm_result: got %h expected %h", got, {16'd19, 16'd22, 16'd43, 16'd50});
        end
        checks++;
        if (bus.OVF !== 1'b0) begin
            errors++;
            $display("FAIL mm_ovf: got %b expected 0", bus.OVF);
        end
    endtask

    task automatic test_overflow();
        int cyc, busy_cyc;
        logic [63:0] got;
        start_op(1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        wait_done(cyc, busy_cyc);
        got = cvec();
        checks++;
        if (cyc !== 9 || got !== {4{16'd64514}}) begin
            errors++;
            $display("FAIL ovf_result: got cycle %0d C=%h expected 9 and %h", cyc, got, {4{16'd64514}});
        end
        checks++;
        if (bus.OVF !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got %b expected 1", bus.OVF);
        end
        start_op(1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        wait_done(cyc, busy_cyc);
        got = cvec();
        checks++;
        if (cyc !== 5 || got !== {4{16'd65025}}) begin
            errors++;
            $display("FAIL ovf_ew_result: got cycle %0d C=%h expected 5 and %h", cyc, got, {4{16'd65025}});
        end
        checks++;
        if (bus.OVF !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b expected 0", bus.OVF);
        end
    endtask

    task automatic test_ignore();
        int ndone, first;
        logic [63:0] got;
        ndone = 0;
        first = 0;
        start_op(1'b1, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (bus.DONE) begin
                ndone++;
                if (first == 0) first = i;
            end
            if (i == 2 || i == 5) begin
                bus.START = 1'b1;
                set_ops(1'b0, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'h33, 8'hCC, 8'h33, 8'hCC);
            end else begin
                bus.START = 1'b0;
            end
        end
        got = cvec();
        checks++;
        if (ndone !== 1 || first !== 9) begin
            errors++;
            $display("FAIL ign_done: got %0d pulses first at %0d expected 1 at 9", ndone, first);
        end
        checks++;
        if (got !== {16'd19, 16'd22, 16'd43, 16'd50}) begin
            errors++;
            $display("FAIL ign_result: got %h expected %h", got, {16'd19, 16'd22, 16'd43, 16'd50});
        end
    endtask

    task automatic test_back_to_back();
        int cnt, accepts;
        logic op_cur;
        logic [63:0] got, exp;
        cnt = 0;
        accepts = 0;
        op_cur = 1'b0;
        @(negedge clk);
        set_ops(1'b0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
        bus.START = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            cnt++;
            if (bus.DONE) begin
                got = cvec();
                exp = op_cur ? {16'd19, 16'd22, 16'd43, 16'd50} : {16'd5, 16'd12, 16'd21, 16'd32};
                checks++;
                if (cnt !== (op_cur ? 9 : 5)) begin
                    errors++;
                    $display("FAIL b2b_period op%0d: got %0d expected %0d", accepts, cnt, op_cur ? 9 : 5);
                end
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL b2b_result op%0d: got %h expected %h", accepts, got, exp);
                end
                accepts++;
                if (accepts == 4) begin
                    bus.START = 1'b0;
                    break;
                end
                op_cur = ~op_cur;
                bus.OP = op_cur;
                cnt = 0;
            end
        end
        checks++;
        if (accepts !== 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d completions expected 4", accepts);
        end
        @(negedge clk);
        checks++;
        if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got DONE=%b BUSY=%b expected 0 0", bus.DONE, bus.BUSY);
        end
    endtask

    task automatic test_reset_midop();
        int cyc, busy_cyc;
        logic [63:0] got;
        start_op(1'b0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
        wait_done(cyc, busy_cyc);
        start_op(1'b1, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
        repeat (5) @(negedge clk);
        got = cvec();
        checks++;
        if (bus.BUSY !== 1'b1 || got !== {16'd19, 16'd22, 16'd21, 16'd32}) begin
            errors++;
            $display("FAIL partial: got BUSY=%b C=%h expected 1 and %h", bus.BUSY, got, {16'd19, 16'd22, 16'd21, 16'd32});
        end
        rst_n = 1'b0;
        #1;
        got = cvec();
        checks++;
        if ({bus.BUSY, bus.DONE, bus.OVF} !== 3'b000 || got !== 64'h0) begin
            errors++;
            $display("FAIL async_reset: got flags=%b C=%h expected 000 and 0", {bus.BUSY, bus.DONE, bus.OVF}, got);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got BUSY=%b DONE=%b expected 0 0", bus.BUSY, bus.DONE);
        end
        start_op(1'b0, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9);
        wait_done(cyc, busy_cyc);
        got = cvec();
        checks++;
        if (cyc !== 5 || got !== {16'd12, 16'd21, 16'd32, 16'd45}) begin
            errors++;
            $display("FAIL post_reset_op: got cycle %0d C=%h expected 5 and %h", cyc, got, {16'd12, 16'd21, 16'd32, 16'd45});
        end
    endtask

    initial begin
        bus.START = 1'b0;
        set_ops(1'b0, '0, '0, '0, '0, '0, '0, '0, '0);
        test_reset();
        test_elementwise();
        test_matmul();
        test_overflow();
        test_ignore();
        test_back_to_back();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
